// File: rtl/tick_stopwatch.sv
// Tick-driven 4-digit BCD stopwatch: synchronises a divider toggle, prescales its edges
// and counts in BCD. Optional lap hold is compiled in with `define TICK_STOPWATCH_LAP_EN.
module tick_stopwatch #(
   parameter int unsigned TICKS_PER_COUNT = 10
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        tick_in,
   input  logic        start_stop,
   input  logic        clear,
`ifdef TICK_STOPWATCH_LAP_EN
   input  logic        lap,
   output logic        lap_active,
`endif
   output logic [15:0] bcd,
   output logic        running,
   output logic        overflow
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2
   } state_t;

   localparam logic [7:0] PRE_LAST = 8'(TICKS_PER_COUNT - 1);

   state_t      r_state;
   logic        r_s1, r_s2, r_s3;
   logic [7:0]  r_prescale;
   logic [15:0] r_count;
   logic        r_running;
   logic        r_overflow;

   logic        w_tick_evt;
   logic [15:0] w_count_inc;
   logic        w_wrap;

   assign w_tick_evt = r_s2 ^ r_s3;

   // Ripple the +1 through the digits; a carry out of d3 is the 9999 -> 0000 wrap.
   always_comb begin
      // NOTE: every variable gets a default before any branch, so no latch is inferred.
      w_count_inc = r_count;
      w_wrap      = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (w_wrap) begin
            if (r_count[4*i +: 4] == 4'd9) begin
               w_count_inc[4*i +: 4] = 4'd0;
            end else begin
               w_count_inc[4*i +: 4] = r_count[4*i +: 4] + 4'd1;
               w_wrap                = 1'b0;
            end
         end
      end
   end

`ifdef TICK_STOPWATCH_LAP_EN
   logic        r_lap_active;
   logic [15:0] r_lap_hold;
`endif

   always_ff @(posedge CLK) begin
      // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
      if (RST) begin
         r_state    <= IDLE;
         r_s1       <= 1'b0;
         r_s2       <= 1'b0;
         r_s3       <= 1'b0;
         r_prescale <= '0;
         r_count    <= '0;
         r_running  <= 1'b0;
         r_overflow <= 1'b0;
`ifdef TICK_STOPWATCH_LAP_EN
         r_lap_active <= 1'b0;
         r_lap_hold   <= '0;
`endif
      end else begin
         r_s1 <= tick_in;
         r_s2 <= r_s1;
         r_s3 <= r_s2;

         if (clear) begin
            r_state    <= IDLE;
            r_prescale <= '0;
            r_count    <= '0;
            r_running  <= 1'b0;
            r_overflow <= 1'b0;
`ifdef TICK_STOPWATCH_LAP_EN
            r_lap_active <= 1'b0;
            r_lap_hold   <= '0;
`endif
         end else begin
            case (r_state)
               IDLE: begin
                  if (start_stop) begin
                     r_state    <= RUN;
                     r_running  <= 1'b1;
                     r_prescale <= '0;
                  end
               end
               RUN: begin
                  // A tick on the pausing cycle is still counted.
                  if (w_tick_evt) begin
                     if (r_prescale >= PRE_LAST) begin
                        r_prescale <= '0;
                        r_count    <= w_count_inc;
                        if (w_wrap) r_overflow <= 1'b1;
                     end else begin
                        r_prescale <= r_prescale + 8'd1;
                     end
                  end
                  if (start_stop) begin
                     r_state   <= PAUSE;
                     r_running <= 1'b0;
                  end
               end
               PAUSE: begin
                  if (start_stop) begin
                     r_state   <= RUN;
                     r_running <= 1'b1;
                  end
               end
               default: begin
                  r_state   <= IDLE;
                  r_running <= 1'b0;
               end
            endcase

`ifdef TICK_STOPWATCH_LAP_EN
            if (lap) begin
               if (r_lap_active) begin
                  r_lap_active <= 1'b0;
               end else if (r_state == RUN) begin
                  r_lap_hold   <= r_count;
                  r_lap_active <= 1'b1;
               end
            end
`endif
         end
      end
   end

`ifdef TICK_STOPWATCH_LAP_EN
   assign lap_active = r_lap_active;
   assign bcd        = r_lap_active ? r_lap_hold : r_count;
`else
   assign bcd        = r_count;
`endif
   assign running  = r_running;
   assign overflow = r_overflow;

endmodule

// File: doc/tick_stopwatch.md
Name: tick_stopwatch

Overview:
Consumer end of the divided timebase. Takes the square-wave toggle produced by the clock divider (one level change per timebase period) and synchronises it into the CLK domain. It detects each level change as a tick event, prescales the ticks, and drives a 4-digit BCD stopwatch count. Start/stop/clear control comes from debounced single-cycle pulses. The BCD output feeds the seven-segment display multiplexer.

Parameters:
TICKS_PER_COUNT, 10, tick events per BCD increment (range 1..255; 10 turns 1 ms toggles into hundredths).

Ports:
CLK  input  1  system clock; all logic on rising edge
RST  input  1  synchronous, active-high reset
tick_in  input  1  toggle from clock divider; every level change (rise or fall) is one tick
start_stop  input  1  single-cycle pulse, CLK domain; start/pause/resume
clear  input  1  single-cycle pulse, CLK domain; zero and stop
bcd  output  16  {d3,d2,d1,d0}, 4 bits per BCD digit, d0 least significant
running  output  1  high while in RUN
overflow  output  1  sticky; set on wrap 9999->0000

Behaviour:
- Reset is synchronous and active-high (RST sampled on the CLK rising edge); single clock CLK.
- RST -> state IDLE, bcd=16'h0000, running=0, overflow=0, prescaler=0, sync flops s1/s2/s3=0.
- Sync: s1<=tick_in, s2<=s1, s3<=s2; tick_evt = s2 ^ s3.
  - A tick_in change is consumed on the 3rd CLK edge after it is first sampled.
  - A tick_in held at 1 through reset gives one tick_evt after release. It is ignored because the block is in IDLE.
- Prescaler: 8-bit, 0..TICKS_PER_COUNT-1.
  - Advances only on tick_evt in RUN.
  - At TICKS_PER_COUNT-1 with tick_evt: prescaler<=0 and the BCD count increments in the same edge.
  - TICKS_PER_COUNT=1: every tick_evt increments the count.
- BCD increment: d0+1. Any digit at 9 wraps to 0 and carries into the next digit.
  - 9999 -> 0000 sets overflow=1; overflow stays set until clear or RST.
  - No binary values above 9 ever appear in a digit.
- FSM states IDLE, RUN, PAUSE; running = (state==RUN):
  - IDLE + start_stop -> RUN; prescaler<=0.
  - RUN + start_stop -> PAUSE. A tick_evt in the same cycle is counted first.
  - PAUSE + start_stop -> RUN; prescaler keeps its value, so a partial count carries over.
  - Any state + clear -> IDLE; bcd<=0, prescaler<=0, overflow<=0.
- Priority: RST > clear > start_stop > tick_evt. A tick_evt coincident with clear is dropped.
- tick_evt in IDLE or PAUSE: no effect.
- Outputs are registered. bcd changes on the same edge that consumes the terminal tick_evt.

Optional Feature:
TICK_STOPWATCH_LAP_EN.
- Defined:
  - Adds input lap (1-bit single-cycle pulse) and output lap_active (1-bit).
  - lap in RUN with lap_active=0: capture the live count into lap_hold and set lap_active=1. bcd shows lap_hold while counting continues internally.
  - lap with lap_active=1 (RUN or PAUSE): lap_active=0; bcd shows the live count on the next cycle.
  - lap in IDLE is ignored.
  - clear/RST: lap_active=0, lap_hold=0.
  - lap and clear in the same cycle: clear wins.
- Undefined: no lap port, no lap_active port, no hold register; bcd always shows the live count.

Test Plan:
- Reset: TICKS_PER_COUNT=2, tick_in toggling, assert RST 3 cycles -> bcd=0000, running=0, overflow=0; no count change while IDLE.
- Latency: start_stop pulse, then toggle tick_in 4 times spaced 20 cycles apart -> bcd=0002, running=1. Each increment lands exactly 3 edges after the 2nd, 4th tick_in change is sampled.
- Pause/resume with partial prescale: RUN, 1 tick, start_stop (PAUSE), 5 ticks, start_stop (RUN), 1 tick -> bcd=0001. The paused ticks are ignored and the partial count is retained.
- Digit carry/overflow: TICKS_PER_COUNT=1, run 9999 ticks -> bcd=9999, overflow=0; one more tick -> bcd=0000, overflow=1; clear -> overflow=0, state IDLE.
- Simultaneous events: in RUN at prescaler terminal, pulse start_stop on the tick_evt cycle -> count increments, then PAUSE. Repeat with clear coincident -> bcd=0000, tick dropped.
- Lap (macro defined): count 0005, lap -> bcd holds 0005 and lap_active=1 while 3 more counts accrue; lap again -> bcd=0008, lap_active=0.
